// File: rtl/serial_frame_scheduler_pkg.sv
// Shared definitions for the BitBakery telemetry frame scheduler: FSM encodings,
// frame geometry and word tags used by the status-word assembly.
package serial_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int NUM_WORDS = 4;

  localparam logic [1:0] TAG_D0 = 2'b00;
  localparam logic [1:0] TAG_D1 = 2'b01;
  localparam logic [1:0] TAG_D2 = 2'b10;
  localparam logic [1:0] TAG_D3 = 2'b11;

  function automatic logic [1:0] next_word(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/serial_frame_scheduler_rr_arbiter_4.sv
// Four-way round-robin pick: first requesting index at or after ptr, modulo 4.
module rr_arbiter_4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] grant_o,
  output logic       valid_o
);

  // Scan from the far end so the closest request to ptr is assigned last.
  always_comb begin
    grant_o = ptr_i;
    valid_o = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req_i[ptr_i + 2'(k)]) begin
        grant_o = ptr_i + 2'(k);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_frame_scheduler.sv
// Schedules the four telemetry words onto the shared UART tx core: changed,
// refreshed or forced words are sent round-robin via a start/done handshake.
module serial_frame_scheduler
  import serial_frame_scheduler_pkg::*;
#(
  parameter int REFRESH_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic       force_send,
  input  logic       tx_pronto,
  output logic       tx_partida,
  output logic [7:0] tx_dados,
  output logic       busy,
  output logic       err_timeout,
  output logic [7:0] frames_sent,
  output logic [2:0] db_estado
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e         state_q, state_d;
  logic [3:0]     dirty_q, dirty_d;
  logic [7:0]     last_sent_q [NUM_WORDS];
  logic [7:0]     last_sent_d [NUM_WORDS];
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     sel_q, sel_d;
  logic [7:0]     tx_dados_q, tx_dados_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           timed_out_q, timed_out_d;
  logic           err_q, err_d;
  logic [7:0]     frames_q, frames_d;
  logic [RW-1:0]  refresh_q, refresh_d;

  logic [7:0]     d_w [NUM_WORDS];
  logic [3:0]     clr_mask, retry_mask, changed;
  logic           refresh_tick;
  logic [1:0]     grant;
  logic           grant_valid;

  assign d_w[0] = d0;
  assign d_w[1] = d1;
  assign d_w[2] = d2;
  assign d_w[3] = d3;

  rr_arbiter_4 u_arb (
    .req_i   (dirty_q),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .valid_o (grant_valid)
  );

  assign refresh_tick = (refresh_q == RW'(REFRESH_CYCLES - 1));
  assign refresh_d    = (refresh_tick || force_send) ? '0 : refresh_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    tx_dados_d  = tx_dados_q;
    tmo_d       = tmo_q;
    timed_out_d = timed_out_q;
    err_d       = err_q;
    frames_d    = frames_q;
    last_sent_d = last_sent_q;
    clr_mask    = '0;
    retry_mask  = '0;

    case (state_q)
      ST_IDLE: if (|dirty_q) state_d = ST_LOAD;
      ST_LOAD: begin
        if (grant_valid) begin
          sel_d              = grant;
          tx_dados_d         = d_w[grant];
          last_sent_d[grant] = d_w[grant];
          clr_mask[grant]    = 1'b1;
          ptr_d              = next_word(grant);
          state_d            = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        tmo_d       = '0;
        timed_out_d = 1'b0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_pronto) begin
          state_d = ST_DONE;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d             = ST_DONE;
          timed_out_d         = 1'b1;
          err_d               = 1'b1;
          retry_mask[sel_q]   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (sel_q == TAG_D3 && !timed_out_q) frames_d = frames_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The word being loaded is compared against its new last_sent value, i.e. itself.
    for (int i = 0; i < NUM_WORDS; i++) begin
      changed[i] = (d_w[i] != last_sent_q[i]) && !clr_mask[i];
    end
    dirty_d = (dirty_q & ~clr_mask) | changed | retry_mask | {4{refresh_tick | force_send}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dirty_q     <= 4'b1111;
      ptr_q       <= '0;
      sel_q       <= '0;
      tx_dados_q  <= '0;
      tmo_q       <= '0;
      timed_out_q <= 1'b0;
      err_q       <= 1'b0;
      frames_q    <= '0;
      refresh_q   <= '0;
      for (int i = 0; i < NUM_WORDS; i++) last_sent_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      tx_dados_q  <= tx_dados_d;
      tmo_q       <= tmo_d;
      timed_out_q <= timed_out_d;
      err_q       <= err_d;
      frames_q    <= frames_d;
      refresh_q   <= refresh_d;
      last_sent_q <= last_sent_d;
    end
  end

  assign tx_partida  = (state_q == ST_START);
  assign tx_dados    = tx_dados_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;
  assign frames_sent = frames_q;
  assign db_estado   = state_q;

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Directed bench for serial_frame_scheduler with a simple tx-core responder.
module tb_serial_frame_scheduler;

  localparam int REFRESH    = 400;
  localparam int TMO        = 16;
  localparam int PRONTO_DLY = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
  logic       force_send = 1'b0;
  logic       tx_pronto;
  logic       pronto_model = 1'b0;
  logic       pronto_manual = 1'b0;
  logic       auto_en = 1'b1;

  logic       tx_partida;
  logic [7:0] tx_dados;
  logic       busy;
  logic       err_timeout;
  logic [7:0] frames_sent;
  logic [2:0] db_estado;

  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;
  int         rel_cyc = 0;
  int         pend = 0;
  int         log_cyc[$];
  logic [7:0] log_dat[$];

  serial_frame_scheduler #(
    .REFRESH_CYCLES (REFRESH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .force_send  (force_send),
    .tx_pronto   (tx_pronto),
    .tx_partida  (tx_partida),
    .tx_dados    (tx_dados),
    .busy        (busy),
    .err_timeout (err_timeout),
    .frames_sent (frames_sent),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;
  assign tx_pronto = pronto_model | pronto_manual;

  always @(posedge clock) cyc <= cyc + 1;

  // tx core stand-in: logs each start and answers PRONTO_DLY cycles later when enabled.
  always @(negedge clock) begin
    if (reset) begin
      pend         <= 0;
      pronto_model <= 1'b0;
    end else begin
      pronto_model <= auto_en && (pend == 1);
      if (tx_partida) begin
        pend <= PRONTO_DLY;
        log_cyc.push_back(cyc);
        log_dat.push_back(tx_dados);
        $display("[cyc %0d] tx word 0x%02h", cyc, tx_dados);
      end else if (pend > 0) begin
        pend <= pend - 1;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_dat.delete();
  endtask

  task automatic apply_reset();
    tick();
    reset   = 1'b1;
    auto_en = 1'b1;
    tick();
    tick();
    clear_log();
    reset   = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_log(input int n, input bit need_idle, input int budget, input string name);
    int k = 0;
    while ((log_dat.size() < n || (need_idle && db_estado != 3'd0)) && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (k >= budget) $display("FAIL %s: wait expired, words seen %0d, required %0d", name, log_dat.size(), n);
    else passed++;
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_partida, tx_dados, busy, err_timeout, frames_sent, db_estado} !== 21'd0)
      $display("FAIL reset_outputs: got partida=%0b dados=%02h busy=%0b err=%0b frames=%0d estado=%0d, required all 0",
               tx_partida, tx_dados, busy, err_timeout, frames_sent, db_estado);
    else passed++;
    d0 = 8'h10; d1 = 8'h41; d2 = 8'h2C; d3 = 8'hA5;
    tick();
    clear_log();
    reset   = 1'b0;
    rel_cyc = cyc;
    wait_log(4, 1'b1, 150, "reset_frame_wait");
    checks++;
    if (log_dat.size() != 4 || log_dat[0] !== 8'h10 || log_dat[1] !== 8'h41 || log_dat[2] !== 8'h2C || log_dat[3] !== 8'hA5)
      $display("FAIL reset_frame_order: got %0d words first=%02h, required 10 41 2C A5", log_dat.size(), log_dat.size() > 0 ? log_dat[0] : 8'hxx);
    else passed++;
    checks++;
    if (log_cyc.size() < 1 || log_cyc[0] - rel_cyc != 2)
      $display("FAIL reset_latency: got %0d cycles, required 2", log_cyc.size() > 0 ? log_cyc[0] - rel_cyc : -1);
    else passed++;
    checks++;
    if (frames_sent !== 8'd1) $display("FAIL reset_frames: got %0d, required 1", frames_sent);
    else passed++;
    // Stray completion while idle must be ignored.
    pronto_manual = 1'b1;
    tick();
    pronto_manual = 1'b0;
    repeat (20) tick();
    checks++;
    if (log_dat.size() != 4 || frames_sent !== 8'd1 || db_estado !== 3'd0)
      $display("FAIL stray_pronto: got words=%0d frames=%0d estado=%0d, required 4 1 0", log_dat.size(), frames_sent, db_estado);
    else passed++;
  endtask

  task automatic test_single_change();
    int c;
    clear_log();
    d1 = 8'h42;
    c  = cyc;
    wait_log(1, 1'b1, 60, "single_wait");
    repeat (20) tick();
    checks++;
    if (log_dat.size() != 1 || log_dat[0] !== 8'h42)
      $display("FAIL single_change_data: got %0d words first=%02h, required 1 word 42", log_dat.size(), log_dat.size() > 0 ? log_dat[0] : 8'hxx);
    else passed++;
    checks++;
    if (log_cyc.size() < 1 || log_cyc[0] - c != 3)
      $display("FAIL single_change_latency: got %0d, required 3", log_cyc.size() > 0 ? log_cyc[0] - c : -1);
    else passed++;
    checks++;
    if (frames_sent !== 8'd1) $display("FAIL single_change_frames: got %0d, required 1", frames_sent);
    else passed++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    wait_log(4, 1'b1, 150, "rr_reset_frame");
    clear_log();
    d1 = 8'h55;
    wait_log(1, 1'b0, 20, "rr_word1_start");
    tick();
    tick();
    checks++;
    if (db_estado !== 3'd3) $display("FAIL rr_in_wait: got state %0d, required 3", db_estado);
    else passed++;
    d0 = 8'h11;
    d2 = 8'h22;
    tick();
    checks++;
    if (tx_dados !== 8'h55) $display("FAIL rr_dados_hold: got %02h, required 55", tx_dados);
    else passed++;
    wait_log(3, 1'b1, 100, "rr_wait");
    checks++;
    if (log_dat.size() != 3 || log_dat[1] !== 8'h22 || log_dat[2] !== 8'h11)
      $display("FAIL rr_order: got %0d words, 2nd=%02h 3rd=%02h, required 22 then 11", log_dat.size(),
               log_dat.size() > 1 ? log_dat[1] : 8'hxx, log_dat.size() > 2 ? log_dat[2] : 8'hxx);
    else passed++;
  endtask

  task automatic test_timeout();
    int waits = 0;
    int k = 0;
    apply_reset();
    wait_log(4, 1'b1, 150, "tmo_reset_frame");
    clear_log();
    checks++;
    if (err_timeout !== 1'b0) $display("FAIL tmo_err_before: got %0b, required 0", err_timeout);
    else passed++;
    auto_en = 1'b0;
    d3 = 8'h5A;
    wait_log(1, 1'b0, 20, "tmo_first_start");
    while (db_estado !== 3'd4 && k < 50) begin
      tick();
      k++;
      if (db_estado === 3'd3) waits++;
    end
    checks++;
    if (waits != TMO) $display("FAIL tmo_wait_len: got %0d cycles, required %0d", waits, TMO);
    else passed++;
    checks++;
    if (err_timeout !== 1'b1) $display("FAIL tmo_err_set: got %0b, required 1", err_timeout);
    else passed++;
    wait_log(2, 1'b0, 20, "tmo_retry_start");
    auto_en = 1'b1;
    checks++;
    if (log_dat.size() != 2 || log_dat[1] !== 8'h5A || log_cyc[1] - log_cyc[0] != TMO + 4)
      $display("FAIL tmo_retry: got words=%0d data=%02h gap=%0d, required 2 5A %0d", log_dat.size(),
               log_dat.size() > 1 ? log_dat[1] : 8'hxx, log_cyc.size() > 1 ? log_cyc[1] - log_cyc[0] : -1, TMO + 4);
    else passed++;
    checks++;
    if (frames_sent !== 8'd1) $display("FAIL tmo_frames_unchanged: got %0d, required 1", frames_sent);
    else passed++;
    wait_log(2, 1'b1, 60, "tmo_retry_done");
    checks++;
    if (frames_sent !== 8'd2 || err_timeout !== 1'b1)
      $display("FAIL tmo_after_retry: got frames=%0d err=%0b, required 2 1", frames_sent, err_timeout);
    else passed++;
  endtask

  task automatic test_refresh();
    int f;
    apply_reset();
    wait_log(8, 1'b1, 700, "refresh_wait");
    checks++;
    if (log_cyc.size() < 8 || log_cyc[4] - log_cyc[0] != REFRESH || log_dat[4] !== d0)
      $display("FAIL refresh_period: got gap=%0d, required %0d", log_cyc.size() > 4 ? log_cyc[4] - log_cyc[0] : -1, REFRESH);
    else passed++;
    repeat (5) tick();
    clear_log();
    f = cyc;
    force_send = 1'b1;
    tick();
    force_send = 1'b0;
    wait_log(8, 1'b1, 700, "force_wait");
    checks++;
    if (log_cyc.size() < 1 || log_cyc[0] - f != 3)
      $display("FAIL force_latency: got %0d, required 3", log_cyc.size() > 0 ? log_cyc[0] - f : -1);
    else passed++;
    checks++;
    if (log_cyc.size() < 8 || log_cyc[4] - log_cyc[0] != REFRESH || log_dat[3] !== d3)
      $display("FAIL force_restart: got gap=%0d, required %0d", log_cyc.size() > 4 ? log_cyc[4] - log_cyc[0] : -1, REFRESH);
    else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wait_log(3, 1'b0, 100, "mid_word2_start");
    tick();
    tick();
    checks++;
    if (db_estado !== 3'd3 || tx_dados !== d2)
      $display("FAIL mid_in_wait: got state=%0d dados=%02h, required 3 %02h", db_estado, tx_dados, d2);
    else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_partida, tx_dados, busy, err_timeout, frames_sent, db_estado} !== 21'd0)
      $display("FAIL mid_reset_outputs: got partida=%0b dados=%02h busy=%0b err=%0b frames=%0d estado=%0d, required all 0",
               tx_partida, tx_dados, busy, err_timeout, frames_sent, db_estado);
    else passed++;
    tick();
    tick();
    clear_log();
    reset   = 1'b0;
    rel_cyc = cyc;
    wait_log(4, 1'b1, 150, "mid_frame_wait");
    checks++;
    if (log_dat.size() != 4 || log_dat[0] !== d0 || log_cyc[0] - rel_cyc != 2 || frames_sent !== 8'd1)
      $display("FAIL mid_restart: got words=%0d first=%02h frames=%0d, required 4 %02h 1", log_dat.size(),
               log_dat.size() > 0 ? log_dat[0] : 8'hxx, frames_sent, d0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_change();
    test_round_robin();
    test_timeout();
    test_refresh();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
